// File: rtl/ram_addr_arbiter.sv
// Registered N-channel arbiter driving a single RAM port.
// Grants one requester per burst (fixed-priority or round-robin) with an optional beat cap.
module ram_addr_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prio_mode,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] addr_in,
  input  logic [NUM_CH-1:0]        we_in,
  input  logic [NUM_CH*DATA_W-1:0] wdata_in,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'((MAX_BURST == 0) ? (2**CNT_W) - 1 : MAX_BURST);
  localparam logic                CAPPED    = (MAX_BURST != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [CH_W-1:0]   cur;
  logic [CH_W-1:0]   last;
  logic [CNT_W-1:0]  count;
  logic [CH_W-1:0]   win_c;
  logic [CH_W-1:0]   idx_c;
  logic              found_c;
  logic              last_beat_c;

  // Winner search: lowest index in fixed mode, otherwise starting just after last winner
  always_comb begin
    win_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (prio_mode) idx_c = CH_W'(k);
      else           idx_c = CH_W'((32'(last) + k + 1) % NUM_CH);
      if (!found_c && req[idx_c]) begin
        win_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  assign last_beat_c = CAPPED && (count == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      count     <= '0;
      cur       <= '0;
      last      <= CH_W'(NUM_CH - 1);
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      case (state)
        IDLE: begin
          if (found_c) begin
            state <= GRANT;
            gnt   <= NUM_CH'(1) << win_c;
            busy  <= 1'b1;
            cur   <= win_c;
            count <= '0;
            if (!prio_mode) last <= win_c;
          end
        end
        GRANT: begin
          if (!req[cur]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else begin
            // Beat: capped final beat is still issued before release
            ram_en    <= 1'b1;
            ram_we    <= we_in[cur];
            ram_addr  <= addr_in[cur*ADDR_W +: ADDR_W];
            ram_wdata <= wdata_in[cur*DATA_W +: DATA_W];
            if (count != CNT_SAT) count <= count + 1'b1;
            if (last_beat_c) begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_cnt_width: assert property (@(posedge clk) disable iff (rst) (MAX_BURST < (2**CNT_W)))
    else $error("MAX_BURST does not fit in CNT_W bits");

endmodule

// File: tb/tb_ram_addr_arbiter.sv
// Scoreboard bench for ram_addr_arbiter: capped instance (MAX_BURST=4) and unlimited instance (MAX_BURST=0).
module tb_ram_addr_arbiter;

  logic        clk;
  logic        rst;
  logic        prio_mode;
  logic [3:0]  req;
  logic [3:0]  req_u;
  logic [63:0] addr_in;
  logic [3:0]  we_in;
  logic [63:0] wdata_in;

  logic [3:0]  gnt, gnt_u;
  logic        busy, busy_u;
  logic        ram_en, ram_en_u;
  logic        ram_we, ram_we_u;
  logic [15:0] ram_addr, ram_addr_u;
  logic [15:0] ram_wdata, ram_wdata_u;

  ram_addr_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .MAX_BURST(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode), .req(req), .addr_in(addr_in),
    .we_in(we_in), .wdata_in(wdata_in), .gnt(gnt), .busy(busy), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  ram_addr_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .MAX_BURST(0), .CNT_W(5)) dut_u (
    .clk(clk), .rst(rst), .prio_mode(prio_mode), .req(req_u), .addr_in(addr_in),
    .we_in(we_in), .wdata_in(wdata_in), .gnt(gnt_u), .busy(busy_u), .ram_en(ram_en_u),
    .ram_we(ram_we_u), .ram_addr(ram_addr_u), .ram_wdata(ram_wdata_u)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_u[$];
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] a, input logic w, input logic [15:0] d);
    addr_in[ch*16 +: 16]  = a;
    we_in[ch]             = w;
    wdata_in[ch*16 +: 16] = d;
  endtask

  // Expected beat appears on the RAM port after the next rising edge
  task automatic push_m(input logic [15:0] a, input logic w, input logic [15:0] d);
    beat_t e;
    e.we = w; e.addr = a; e.data = d; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_u(input logic [15:0] a, input logic w, input logic [15:0] d);
    beat_t e;
    e.we = w; e.addr = a; e.data = d; e.due = cyc + 1;
    exp_u.push_back(e);
  endtask

  always @(negedge clk) begin : mon_main
    beat_t e;
    if (ram_en) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL main_unexpected_beat: got addr %0h expected no beat (cycle %0d)", ram_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        check("main_addr", 32'(ram_addr), 32'(e.addr));
        check("main_we", 32'(ram_we), 32'(e.we));
        check("main_wdata", 32'(ram_wdata), 32'(e.data));
        check("main_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      check("main_idle_addr", 32'({ram_we, ram_addr, ram_wdata}), 32'h0);
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n_vec++; n_fail++;
        $display("FAIL main_missing_beat: got ram_en 0 expected beat addr %0h (cycle %0d)", e.addr, cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_unl
    beat_t e;
    if (ram_en_u) begin
      if (exp_u.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unl_unexpected_beat: got addr %0h expected no beat (cycle %0d)", ram_addr_u, cyc);
      end else begin
        e = exp_u.pop_front();
        check("unl_addr", 32'(ram_addr_u), 32'(e.addr));
        check("unl_we", 32'(ram_we_u), 32'(e.we));
        check("unl_wdata", 32'(ram_wdata_u), 32'(e.data));
        check("unl_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (exp_u.size() != 0 && exp_u[0].due <= cyc) begin
      e = exp_u.pop_front();
      n_vec++; n_fail++;
      $display("FAIL unl_missing_beat: got ram_en 0 expected beat addr %0h (cycle %0d)", e.addr, cyc);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int na;
    rst = 1'b1; prio_mode = 1'b1; req = '0; req_u = '0;
    addr_in = '0; we_in = '0; wdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ram", 32'({ram_en, ram_we, ram_addr}), 32'h0);
    check("rst_wdata", 32'(ram_wdata), 32'h0);
    check("rst_gnt_u", 32'(gnt_u), 32'h0);
    rst = 1'b0;
    tick();

    // Single channel, fixed mode: ch2 three beats
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    for (int b = 0; b < 3; b++) begin
      set_ch(2, 16'(16'h0100 + b), 1'b1, 16'(16'hA000 + b));
      push_m(16'(16'h0100 + b), 1'b1, 16'(16'hA000 + b));
      tick();
    end
    req = 4'b0000;
    tick();
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_busy", 32'(busy), 32'h0);
    tick();
    check("single_idle_gnt", 32'(gnt), 32'h0);

    // Fixed priority: ch1 over ch3, ch3 after one idle cycle
    req = 4'b1010;
    tick();
    check("fixed_gnt_ch1", 32'(gnt), 32'h2);
    for (int b = 0; b < 2; b++) begin
      set_ch(1, 16'(16'h0200 + b), 1'b0, 16'(16'h5500 + b));
      set_ch(3, 16'(16'h0300 + b), 1'b1, 16'h3300);
      push_m(16'(16'h0200 + b), 1'b0, 16'(16'h5500 + b));
      tick();
    end
    req = 4'b1000;
    tick();
    check("fixed_idle_gap", 32'(gnt), 32'h0);
    tick();
    check("fixed_gnt_ch3", 32'(gnt), 32'h8);
    set_ch(3, 16'h0300, 1'b1, 16'h3333);
    push_m(16'h0300, 1'b1, 16'h3333);
    tick();
    req = 4'b0000;
    tick();
    check("fixed_rel", 32'(gnt), 32'h0);

    // Burst cap of 4 on ch0; requester advances address only on accepted beats
    na = 0;
    req = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      set_ch(0, 16'(na), 1'b1, ~16'(na));
      if (e != 0 && e != 5) begin
        push_m(16'(na), 1'b1, ~16'(na));
        na++;
      end
      tick();
      if (e == 4) check("cap_release", 32'(gnt), 32'h0);
      if (e == 5) check("cap_regrant", 32'(gnt), 32'h1);
      if (e == 9) check("cap_release2", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a ch1 burst
    req = 4'b0010;
    tick();
    check("mid_gnt", 32'(gnt), 32'h2);
    for (int b = 0; b < 3; b++) begin
      set_ch(1, 16'(16'h0400 + b), 1'b1, 16'(16'h4400 + b));
      push_m(16'(16'h0400 + b), 1'b1, 16'(16'h4400 + b));
      tick();
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_ram", 32'({ram_en, ram_addr}), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b0001;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("post_rst_rel", 32'(gnt), 32'h0);

    // Round-robin from a fresh pointer: ch0,1,2,3,0, four beats each
    rst = 1'b1;
    #2 rst = 1'b0;
    prio_mode = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << g));
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 4; i++) set_ch(i, 16'(i * 256 + b), b[0], ~16'(i * 256 + b));
        push_m(16'(g * 256 + b), b[0], ~16'(g * 256 + b));
        tick();
      end
      check("rr_release", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    tick();

    // Unlimited burst: ch1 keeps the grant for 100 beats despite other requests
    prio_mode = 1'b1;
    req_u = 4'b0010;
    tick();
    check("unl_gnt", 32'(gnt_u), 32'h2);
    for (int b = 0; b < 100; b++) begin
      req_u = 4'b1111;
      set_ch(1, 16'(16'h1000 + b), b[0], 16'(16'h2000 + b));
      push_u(16'(16'h1000 + b), b[0], 16'(16'h2000 + b));
      tick();
      if (b % 25 == 24) begin
        check("unl_hold_gnt", 32'(gnt_u), 32'h2);
        check("unl_hold_busy", 32'(busy_u), 32'h1);
      end
    end
    req_u = 4'b1101;
    tick();
    check("unl_rel", 32'(gnt_u), 32'h0);
    tick();
    check("unl_next_ch0", 32'(gnt_u), 32'h1);
    req_u = 4'b0000;
    tick();
    check("unl_final_rel", 32'(gnt_u), 32'h0);

    repeat (3) tick();
    check("main_queue_drained", 32'(exp_q.size()), 32'h0);
    check("unl_queue_drained", 32'(exp_u.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
